uart_tx_fifo_ctrl: RTL and testbench

UART_TX_FIFO_CTRL -- requirements
Module: uart_tx_fifo_ctrl

---
 rtl/uart_pkg.sv | 14 +
 rtl/uart_gap_timer.sv | 28 ++
 rtl/uart_tx_fifo_ctrl.sv | 76 +++++++
 tb/tb_uart_tx_fifo_ctrl.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: transmit-controller state encoding and frame-counter width.
package uart_pkg;

  localparam int FRAME_CNT_W = 16;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_POP       = 3'd1;
  localparam logic [2:0] ST_CAPTURE   = 3'd2;
  localparam logic [2:0] ST_START     = 3'd3;
  localparam logic [2:0] ST_WAIT_ACK  = 3'd4;
  localparam logic [2:0] ST_WAIT_DONE = 3'd5;
  localparam logic [2:0] ST_GAP       = 3'd6;

endpackage

// File: rtl/uart_gap_timer.sv
// Loadable down-counter that flags its last counting clock; shared by UART TX and RX.
module uart_gap_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             count,
  output logic             done
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (count && cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  // done marks the clock on which the count reaches its final value of 1
  assign done = (cnt == CNT_W'(1));

endmodule

// File: rtl/uart_tx_fifo_ctrl.sv
// Pulls bytes from an external TX FIFO and hands them one frame at a time to a UART transmitter.
module uart_tx_fifo_ctrl
  import uart_pkg::*;
#(
  parameter int DATA_SIZE = 8,
  parameter int GAP_BITS  = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable,
  input  logic [GAP_BITS-1:0]    gap_cycles,
  input  logic                   fifo_empty,
  input  logic [DATA_SIZE-1:0]   fifo_data,
  output logic                   fifo_rd_en,
  input  logic                   tx_busy,
  output logic                   tx_start,
  output logic [DATA_SIZE-1:0]   tx_data,
  output logic [FRAME_CNT_W-1:0] frames_sent,
  output logic                   active
);

  logic [2:0] state;
  logic [2:0] next_state;
  logic       frame_done;
  logic       gap_load;
  logic       gap_done;

  assign frame_done = (state == ST_WAIT_DONE) && !tx_busy;
  // gap_cycles is sampled only here, so later edits never stretch or cut the running gap
  assign gap_load   = frame_done && (gap_cycles != '0);

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:      if (enable && !fifo_empty) next_state = ST_POP;
      ST_POP:       next_state = ST_CAPTURE;
      ST_CAPTURE:   next_state = ST_START;
      ST_START:     next_state = ST_WAIT_ACK;
      ST_WAIT_ACK:  if (tx_busy) next_state = ST_WAIT_DONE;
      ST_WAIT_DONE: if (!tx_busy) next_state = (gap_cycles == '0) ? ST_IDLE : ST_GAP;
      ST_GAP:       if (gap_done) next_state = ST_IDLE;
      default:      next_state = ST_IDLE;
    endcase
  end

  uart_gap_timer #(
    .CNT_W(GAP_BITS)
  ) u_gap_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (gap_load),
    .load_val (gap_cycles),
    .count    (state == ST_GAP),
    .done     (gap_done)
  );

  // Strobes are decoded from next_state so they are registered yet coincide with their state
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      fifo_rd_en  <= 1'b0;
      tx_start    <= 1'b0;
      active      <= 1'b0;
      tx_data     <= '0;
      frames_sent <= '0;
    end else begin
      state      <= next_state;
      fifo_rd_en <= (next_state == ST_POP);
      tx_start   <= (next_state == ST_START);
      active     <= (next_state != ST_IDLE);
      if (state == ST_CAPTURE) tx_data <= fifo_data;
      if (frame_done) frames_sent <= frames_sent + 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo_ctrl.sv
// Bench for uart_tx_fifo_ctrl: FIFO and transmitter models plus a payload scoreboard.
module tb_uart_tx_fifo_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [7:0]  gap_cycles;
  logic        fifo_empty;
  logic [7:0]  fifo_data = 8'h00;
  logic        fifo_rd_en;
  logic        tx_busy = 1'b0;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic [15:0] frames_sent;
  logic        active;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [7:0] mem [64];
  int push_cnt = 0;
  int pop_cnt  = 0;
  int busy_len = 10;
  int busy_left = 0;
  int rd_cnt = 0;
  logic prev_rd = 1'b0;
  logic [7:0] exp_q [$];
  int starts [$];

  uart_tx_fifo_ctrl #(
    .DATA_SIZE(8),
    .GAP_BITS (8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .gap_cycles  (gap_cycles),
    .fifo_empty  (fifo_empty),
    .fifo_data   (fifo_data),
    .fifo_rd_en  (fifo_rd_en),
    .tx_busy     (tx_busy),
    .tx_start    (tx_start),
    .tx_data     (tx_data),
    .frames_sent (frames_sent),
    .active      (active)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // FIFO model: registered read data, valid one clock after rd_en
  assign fifo_empty = (push_cnt == pop_cnt);
  always @(posedge clk) begin
    if (fifo_rd_en && push_cnt != pop_cnt) begin
      fifo_data <= mem[pop_cnt % 64];
      pop_cnt   <= pop_cnt + 1;
    end
  end

  // Transmitter model: busy rises the clock after tx_start and stays up busy_len clocks
  always @(posedge clk) begin
    if (rst) begin
      tx_busy <= 1'b0;
    end else if (tx_start) begin
      tx_busy   <= 1'b1;
      busy_left <= busy_len - 1;
    end else if (tx_busy) begin
      if (busy_left == 0) tx_busy <= 1'b0;
      else busy_left <= busy_left - 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (fifo_rd_en) begin
      rd_cnt++;
      chk("rd_nonempty", 32'(push_cnt != pop_cnt), 32'd1);
      chk("rd_pulse", 32'(prev_rd), 32'd0);
    end
    prev_rd = fifo_rd_en;
    if (tx_start) begin
      starts.push_back(cyc);
      chk("sb_avail", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) chk("sb_data", 32'(tx_data), 32'(exp_q.pop_front()));
    end
  end

  task automatic push(input logic [7:0] b);
    mem[push_cnt % 64] = b;
    push_cnt++;
    exp_q.push_back(b);
  endtask

  task automatic wait_frames(input int n, input int lim);
    for (int i = 0; i < lim && frames_sent != 16'(n); i++) @(negedge clk);
    chk("frames_sent", 32'(frames_sent), 32'(n));
  endtask

  task automatic wait_idle(input int lim);
    for (int i = 0; i < lim && active; i++) @(negedge clk);
    chk("back_idle", 32'(active), 32'd0);
  endtask

  task automatic wait_busy(input logic lvl, input int lim);
    for (int i = 0; i < lim && tx_busy != lvl; i++) @(negedge clk);
    chk("busy_level", 32'(tx_busy), 32'(lvl));
  endtask

  initial begin
    int pc, rd0, s0;
    logic any_rd, any_act;
    rst = 1'b1;
    enable = 1'b0;
    gap_cycles = 8'd0;
    repeat (3) @(negedge clk);
    chk("rst_rd_en", 32'(fifo_rd_en), 32'd0);
    chk("rst_start", 32'(tx_start), 32'd0);
    chk("rst_active", 32'(active), 32'd0);
    chk("rst_frames", 32'(frames_sent), 32'd0);
    chk("rst_data", 32'(tx_data), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Single byte, no gap: start follows the IDLE evaluation by POP, CAPTURE, START
    enable = 1'b1;
    rd0 = rd_cnt;
    s0 = starts.size();
    pc = cyc;
    push(8'hA5);
    wait_frames(1, 100);
    chk("s1_latency", 32'(starts.size() > s0 ? starts[s0] - pc : -1), 32'd3);
    chk("s1_rd_count", 32'(rd_cnt - rd0), 32'd1);
    chk("s1_data_held", 32'(tx_data), 32'hA5);
    wait_idle(20);

    // Three bytes, gap 4: starts spaced by ack(1) + busy + exit(1) + gap + IDLE/POP/CAPTURE(3)
    gap_cycles = 8'd4;
    s0 = starts.size();
    push(8'h11); push(8'h22); push(8'h33);
    wait_frames(4, 200);
    wait_idle(20);
    chk("s2_starts", 32'(starts.size() - s0), 32'd3);
    if (starts.size() - s0 == 3) begin
      chk("s2_space1", 32'(starts[s0+1] - starts[s0]), 32'(1 + busy_len + 1 + 4 + 3));
      chk("s2_space2", 32'(starts[s0+2] - starts[s0+1]), 32'(1 + busy_len + 1 + 4 + 3));
    end

    // Disabled with data waiting: nothing moves, then POP on the next clock
    enable = 1'b0;
    push(8'h44);
    any_rd = 1'b0;
    any_act = 1'b0;
    repeat (50) begin
      @(negedge clk);
      any_rd  = any_rd | fifo_rd_en;
      any_act = any_act | active;
    end
    chk("s3_no_rd", 32'(any_rd), 32'd0);
    chk("s3_no_active", 32'(any_act), 32'd0);
    enable = 1'b1;
    @(negedge clk);
    chk("s3_pop_next", 32'(fifo_rd_en), 32'd1);
    wait_frames(5, 100);
    wait_idle(20);

    // Enable dropped during WAIT_DONE: frame completes, nothing further popped
    gap_cycles = 8'd0;
    rd0 = rd_cnt;
    push(8'h55); push(8'h66); push(8'h77);
    wait_busy(1'b1, 50);
    repeat (2) @(negedge clk);
    enable = 1'b0;
    repeat (40) @(negedge clk);
    chk("s4_frames", 32'(frames_sent), 32'd6);
    chk("s4_rd_count", 32'(rd_cnt - rd0), 32'd1);
    chk("s4_fifo_left", 32'(push_cnt - pop_cnt), 32'd2);
    chk("s4_active", 32'(active), 32'd0);

    // Reset in WAIT_DONE: popped byte lost, counter cleared, next byte sent after release
    enable = 1'b1;
    wait_busy(1'b1, 50);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("s5_rd_en", 32'(fifo_rd_en), 32'd0);
    chk("s5_start", 32'(tx_start), 32'd0);
    chk("s5_active", 32'(active), 32'd0);
    chk("s5_frames", 32'(frames_sent), 32'd0);
    chk("s5_data", 32'(tx_data), 32'd0);
    rst = 1'b0;
    wait_frames(1, 100);
    wait_idle(20);
    chk("s5_fifo_left", 32'(push_cnt - pop_cnt), 32'd0);

    // Gap length latched at WAIT_DONE exit: editing it mid-gap has no effect
    gap_cycles = 8'd5;
    s0 = starts.size();
    push(8'h88); push(8'h99);
    wait_busy(1'b1, 50);
    wait_busy(1'b0, 50);
    repeat (2) @(negedge clk);
    gap_cycles = 8'd1;
    wait_frames(3, 200);
    wait_idle(20);
    chk("s6_starts", 32'(starts.size() - s0), 32'd2);
    if (starts.size() - s0 == 2)
      chk("s6_space", 32'(starts[s0+1] - starts[s0]), 32'(1 + busy_len + 1 + 5 + 3));

    chk("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
